// File: rtl/nl_pkg.sv
// Shared constants, metric mode enum and width helper for the NL router
// congestion preselector.
package nl_pkg;

    localparam int NORTH = 0;
    localparam int EAST  = 1;
    localparam int SOUTH = 2;
    localparam int WEST  = 3;
    localparam int LOCAL = 4;

    localparam int NE = 0;
    localparam int NW = 1;
    localparam int SE = 2;
    localparam int SW = 3;

    typedef enum logic [1:0] {
        CM_BUF    = 2'd0,
        CM_VC     = 2'd1,
        CM_HYBRID = 2'd2
    } cong_mode_e;

    // Worst case is HYBRID: NV*BUF_DEPTH flits plus NV busy VCs * BUF_DEPTH.
    function automatic int cong_w(input int nv, input int buf_depth);
        return $clog2(2 * nv * buf_depth + 1);
    endfunction

    // Quadrant leg a is the N/S port, leg b the E/W port.
    function automatic int quad_a(input int q);
        return (q == NE || q == NW) ? NORTH : SOUTH;
    endfunction

    function automatic int quad_b(input int q);
        return (q == NE || q == SE) ? EAST : WEST;
    endfunction

endpackage

// File: rtl/nl_vc_occ_counter.sv
// One (port, VC) slice: outstanding-flit counter with saturation, VC
// ownership tracking, and a one-cycle err pulse on under/overflow.
module nl_vc_occ_counter
    import nl_pkg::*;
#(
    parameter  int NV        = 4,
    parameter  int BUF_DEPTH = 4,
    parameter  int VC_ID     = 0,
    localparam int VW        = $clog2(NV),
    localparam int OW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flit_valid_i,
    input  logic [VW-1:0] flit_vc_i,
    input  logic          flit_head_i,
    input  logic          flit_tail_i,
    input  logic          credit_valid_i,
    input  logic [VW-1:0] credit_vc_i,
    output logic [OW-1:0] occ_d_o,
    output logic          busy_d_o,
    output logic          err_o
);

    localparam logic [OW-1:0] OCC_MAX = OW'(BUF_DEPTH);

    logic [OW-1:0] occ_q, occ_d;
    logic          busy_q, busy_d;
    logic          tail_q, tail_d;
    logic          inc, dec;

    assign inc = flit_valid_i   && (flit_vc_i   == VW'(VC_ID));
    assign dec = credit_valid_i && (credit_vc_i == VW'(VC_ID));

    always_comb begin
        occ_d  = occ_q;
        busy_d = busy_q;
        tail_d = tail_q;
        err_o  = 1'b0;
        if (inc && !dec) begin
            if (occ_q == OCC_MAX) err_o = 1'b1;
            else                  occ_d = occ_q + 1'b1;
        end else if (dec && !inc) begin
            if (occ_q == '0) err_o = 1'b1;
            else             occ_d = occ_q - 1'b1;
        end
        if (inc && flit_head_i) begin
            busy_d = 1'b1;
            tail_d = 1'b0;
        end
        if (inc && flit_tail_i) tail_d = 1'b1;
        // Packet fully drained downstream: VC returns to the free pool.
        if (occ_d == '0 && tail_d) begin
            busy_d = 1'b0;
            tail_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q  <= '0;
            busy_q <= 1'b0;
            tail_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            busy_q <= busy_d;
            tail_q <= tail_d;
        end
    end

    assign occ_d_o  = occ_d;
    assign busy_d_o = busy_d;

endmodule

// File: rtl/nl_congestion_preselect.sv
// Per-port congestion metric, quadrant preselect and free-VC masks.
// Define CONG_HYST_EN to add HYST-margin hysteresis to the quadrant compare.
module nl_congestion_preselect
    import nl_pkg::*;
#(
    parameter  int NV        = 4,
    parameter  int NP        = 5,
    parameter  int BUF_DEPTH = 4,
    parameter  int MODE      = 0,
    parameter  int HYST      = 2,
    localparam int VW        = $clog2(NV),
    localparam int OW        = $clog2(BUF_DEPTH + 1),
    localparam int CW        = cong_w(NV, BUF_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NP-1:0]          flit_valid_i,
    input  logic [NP-1:0][VW-1:0]  flit_vc_i,
    input  logic [NP-1:0]          flit_head_i,
    input  logic [NP-1:0]          flit_tail_i,
    input  logic [NP-1:0]          credit_valid_i,
    input  logic [NP-1:0][VW-1:0]  credit_vc_i,
    output logic [3:0]             select_o,
    output logic [NP-1:0][NV-1:0]  vc_mask_o,
    output logic [NP-1:0][CW-1:0]  cong_o,
    output logic                   err_o
);

    localparam logic [CW-1:0] BD_W = CW'(BUF_DEPTH);

    if (NV < 2 || HYST < 0 || MODE < 0 || MODE > 2) begin : g_bad_cfg
        $error("nl_congestion_preselect: illegal NV/HYST/MODE");
    end

    logic [NP-1:0][NV-1:0][OW-1:0] occ_d;
    logic [NP-1:0][NV-1:0]         busy_d;
    logic [NP-1:0][NV-1:0]         err_pulse;
    logic [NP-1:0][CW-1:0]         osum, vsum, metric_d, cong_q;
    logic [NP-1:0][NV-1:0]         mask_q;
    logic [3:0]                    sel_q, sel_d;
    logic                          err_q;

    for (genvar p = 0; p < NP; p++) begin : g_port
        for (genvar v = 0; v < NV; v++) begin : g_vc
            nl_vc_occ_counter #(
                .NV(NV), .BUF_DEPTH(BUF_DEPTH), .VC_ID(v)
            ) u_cnt (
                .clk            (clk),
                .rst_n          (rst_n),
                .flit_valid_i   (flit_valid_i[p]),
                .flit_vc_i      (flit_vc_i[p]),
                .flit_head_i    (flit_head_i[p]),
                .flit_tail_i    (flit_tail_i[p]),
                .credit_valid_i (credit_valid_i[p]),
                .credit_vc_i    (credit_vc_i[p]),
                .occ_d_o        (occ_d[p][v]),
                .busy_d_o       (busy_d[p][v]),
                .err_o          (err_pulse[p][v])
            );
        end
    end

    // Metric is built from next-state values so outputs lag inputs by one cycle.
    always_comb begin
        osum     = '0;
        vsum     = '0;
        metric_d = '0;
        for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < NV; v++) begin
                osum[p] = osum[p] + CW'(occ_d[p][v]);
                if (busy_d[p][v]) vsum[p] = vsum[p] + BD_W;
            end
            if (MODE == int'(CM_BUF))     metric_d[p] = osum[p];
            else if (MODE == int'(CM_VC)) metric_d[p] = vsum[p];
            else                          metric_d[p] = osum[p] + vsum[p];
        end
    end

    always_comb begin
        sel_d = sel_q;
        for (int q = 0; q < 4; q++) begin
`ifdef CONG_HYST_EN
            if (!sel_q[q] && int'(metric_d[quad_a(q)]) + HYST < int'(metric_d[quad_b(q)]))
                sel_d[q] = 1'b1;
            else if (sel_q[q] && int'(metric_d[quad_b(q)]) + HYST < int'(metric_d[quad_a(q)]))
                sel_d[q] = 1'b0;
`else
            sel_d[q] = metric_d[quad_a(q)] < metric_d[quad_b(q)];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q  <= '0;
            mask_q <= '1;
            cong_q <= '0;
            err_q  <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            mask_q <= ~busy_d;
            cong_q <= metric_d;
            err_q  <= err_q | (|err_pulse);
        end
    end

    assign select_o  = sel_q;
    assign vc_mask_o = mask_q;
    assign cong_o    = cong_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_nl_congestion_preselect.sv
// Scoreboard bench: three DUTs (BUF/VC/HYBRID) share one stimulus stream,
// a rule-level model predicts outputs, a monitor compares each cycle.
module tb_nl_congestion_preselect;
    import nl_pkg::*;

    localparam int NV = 4, NP = 5, BD = 4, HY = 2;
    localparam int CW = cong_w(NV, BD);

    typedef struct packed {
        logic [2:0][3:0]          sel;
        logic [NP-1:0][NV-1:0]    mask;
        logic [2:0][NP-1:0][CW-1:0] cong;
        logic                     err;
    } exp_t;

    logic clk, rst_n;
    logic [NP-1:0]       fv, fh, ft, cv;
    logic [NP-1:0][1:0]  fvc, cvc;

    logic [3:0]            sel_o  [3];
    logic [NP-1:0][NV-1:0] mask_o [3];
    logic [NP-1:0][CW-1:0] cong_o [3];
    logic                  err_o  [3];

    for (genvar m = 0; m < 3; m++) begin : g_dut
        nl_congestion_preselect #(.NV(NV), .NP(NP), .BUF_DEPTH(BD), .MODE(m), .HYST(HY)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .flit_valid_i(fv), .flit_vc_i(fvc), .flit_head_i(fh), .flit_tail_i(ft),
            .credit_valid_i(cv), .credit_vc_i(cvc),
            .select_o(sel_o[m]), .vc_mask_o(mask_o[m]), .cong_o(cong_o[m]), .err_o(err_o[m])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    exp_t q[$];

    // Reference state: outstanding flit count and packet ownership per (port, VC).
    int  m_occ  [NP][NV];
    bit  m_own  [NP][NV];
    bit  m_tail [NP][NV];
    bit  m_err;
    bit  [2:0][3:0] m_sel;
    int  QA[4] = '{0, 0, 2, 2};
    int  QB[4] = '{1, 3, 1, 3};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(output exp_t e);
        int met[3][NP];
        foreach (met[m, p]) met[m][p] = 0;
        if (!rst_n) begin
            foreach (m_occ[p, v]) begin m_occ[p][v] = 0; m_own[p][v] = 0; m_tail[p][v] = 0; end
            m_err = 0;
            m_sel = '0;
        end else begin
            for (int p = 0; p < NP; p++)
                for (int v = 0; v < NV; v++) begin
                    bit f = fv[p] && fvc[p] == v;
                    bit c = cv[p] && cvc[p] == v;
                    int want = m_occ[p][v] + (f ? 1 : 0) - (c ? 1 : 0);
                    if (want > BD || want < 0) m_err = 1;
                    else m_occ[p][v] = want;
                    if (f && fh[p]) begin m_own[p][v] = 1; m_tail[p][v] = 0; end
                    if (f && ft[p]) m_tail[p][v] = 1;
                    if (m_occ[p][v] == 0 && m_tail[p][v]) begin m_own[p][v] = 0; m_tail[p][v] = 0; end
                end
            for (int p = 0; p < NP; p++) begin
                int flits = 0, owned = 0;
                for (int v = 0; v < NV; v++) begin
                    flits += m_occ[p][v];
                    owned += m_own[p][v] ? 1 : 0;
                end
                met[0][p] = flits;
                met[1][p] = owned * BD;
                met[2][p] = flits + owned * BD;
            end
            for (int m = 0; m < 3; m++)
                for (int k = 0; k < 4; k++) begin
                    int a = met[m][QA[k]], b = met[m][QB[k]];
`ifdef CONG_HYST_EN
                    if (!m_sel[m][k] && a + HY < b) m_sel[m][k] = 1;
                    else if (m_sel[m][k] && b + HY < a) m_sel[m][k] = 0;
`else
                    m_sel[m][k] = (a < b);
`endif
                end
        end
        e.sel = m_sel;
        e.err = m_err;
        for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < NV; v++) e.mask[p][v] = !m_own[p][v];
            for (int m = 0; m < 3; m++) e.cong[m][p] = CW'(met[m][p]);
        end
    endtask

    task automatic clr();
        fv = '0; fh = '0; ft = '0; cv = '0; fvc = '0; cvc = '0;
    endtask

    task automatic tick();
        exp_t e;
        model_step(e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        clr();
    endtask

    task automatic flit(input int p, input int v, input bit h, input bit t);
        fv[p] = 1'b1; fvc[p] = 2'(v); fh[p] = h; ft[p] = t;
    endtask

    task automatic cred(input int p, input int v);
        cv[p] = 1'b1; cvc[p] = 2'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            fv = NP'($urandom); fh = NP'($urandom); ft = NP'($urandom); cv = NP'($urandom);
            fvc = (2*NP)'($urandom); cvc = (2*NP)'($urandom);
            tick();
        end
        rst_n = 1'b1;
        tick();
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("select[m%0d]", m), 64'(sel_o[m]),  64'(e.sel[m]));
                chk($sformatf("vc_mask[m%0d]", m), 64'(mask_o[m]), 64'(e.mask));
                chk($sformatf("cong[m%0d]", m),   64'(cong_o[m]), 64'(e.cong[m]));
                chk($sformatf("err[m%0d]", m),    64'(err_o[m]),  64'(e.err));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr();
        @(negedge clk);
        do_reset();

        // BUF metric: N VC0 x3, E VC2 x1, then drain N
        repeat (3) begin flit(NORTH, 0, 0, 0); tick(); end
        flit(EAST, 2, 0, 0); tick();
        repeat (3) begin cred(NORTH, 0); tick(); end
        tick();

        // Ownership on WEST VC1
        do_reset();
        flit(WEST, 1, 1, 0); tick();
        flit(WEST, 1, 0, 1); tick();
        cred(WEST, 1); tick();
        cred(WEST, 1); tick();
        tick();

        // Single-flit packet with a same-cycle credit on an empty VC
        flit(EAST, 3, 1, 1); cred(EAST, 3); tick();
        tick();

        // Saturation and underflow
        do_reset();
        repeat (5) begin flit(SOUTH, 3, 0, 0); tick(); end
        cred(SOUTH, 0); tick();
        tick();

        // Simultaneous flit/credit
        do_reset();
        flit(NORTH, 0, 0, 0); tick();
        flit(NORTH, 0, 0, 0); tick();
        flit(NORTH, 1, 0, 0); tick();
        flit(NORTH, 0, 0, 0); cred(NORTH, 0); tick();
        flit(NORTH, 0, 0, 0); cred(NORTH, 1); tick();
        tick();

        // Hysteresis walk: N=3,E=4 -> E=6 -> N=5 -> N=9
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) flit(NORTH, 0, 0, 0);
            flit(EAST, 0, 0, 0);
            tick();
        end
        repeat (2) begin flit(EAST, 1, 0, 0); tick(); end
        repeat (2) begin flit(NORTH, 1, 0, 0); tick(); end
        repeat (4) begin flit(NORTH, 2, 0, 0); tick(); end
        tick();

        // Randomized traffic with occasional mid-packet resets
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                continue;
            end
            for (int p = 0; p < NP; p++) begin
                int v = $urandom_range(0, NV - 1);
                if ($urandom_range(0, 1) == 1 && (m_occ[p][v] < BD || $urandom_range(0, 9) == 0))
                    flit(p, v, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
                if ($urandom_range(0, 9) < 4) begin
                    int c = $urandom_range(0, NV - 1);
                    if ($urandom_range(0, 9) != 0)
                        for (int k = 0; k < NV; k++)
                            if (m_occ[p][(c + k) % NV] > 0) begin c = (c + k) % NV; break; end
                    cred(p, c);
                end
            end
            tick();
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nl_congestion_preselect.md
# nl_congestion_preselect

Per-VC congestion tracker and route preselector for the NL router output stage. It counts outstanding flits per output port and per VC, and records VC ownership from head and tail flits. From these it forms a configurable per-port congestion metric. It emits registered quadrant preferences (NE/NW/SE/SW) and per-port free-VC masks to the adaptive route-compute and VC-allocation stages.

## Interface
- NV, 4, VCs per port (≥2)
- NP, 5, ports; indices NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4 from package
- BUF_DEPTH, 4, downstream buffer depth per VC (credits)
- MODE, 0, metric: 0=BUF (sum of outstanding flits), 1=VC (busy VCs × BUF_DEPTH), 2=HYBRID (sum of both)
- HYST, 2, hysteresis margin (used only with CONG_HYST_EN)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flit_valid  in  [NP]  flit sent on output port p this cycle
- flit_vc  in  [NP][log2 NV]  VC of the sent flit
- flit_head / flit_tail  in  [NP]  control bits of the sent flit (head+tail = single-flit packet)
- credit_valid  in  [NP]  credit returned on port p
- credit_vc  in  [NP][log2 NV]  VC of the returned credit
- select  out  [4]  quadrant preference, 1 = prefer the N/S leg, 0 = prefer the E/W leg
- vc_mask  out  [NP][NV]  1 = VC free for allocation
- cong  out  [NP][CW]  registered port metric, CW = clog2(2·NV·BUF_DEPTH+1)
- err  out  1  sticky counter underflow/overflow flag

## Operation
- Per (port, VC) state:
  - occ counter, range 0..BUF_DEPTH
  - busy flag
  - tail_sent flag
- occ update:
  - +1 on a flit to that VC; −1 on a credit to that VC.
  - Simultaneous flit and credit on the same VC leave occ unchanged.
  - Events on different VCs of one port all apply in the same cycle.
- Boundary conditions:
  - Increment at BUF_DEPTH saturates (holds) and sets err.
  - Decrement at 0 holds and sets err.
  - err clears only on reset.
- Ownership:
  - A head flit sets busy and clears tail_sent.
  - A tail flit sets tail_sent.
  - busy clears in the cycle occ_next==0 with tail_sent (or the tail arriving) set.
  - Head+tail with a same-cycle credit at occ=0 leaves busy=0.
- Metric: computed from next-state values (occ_next, busy_next), summed over VCs, per MODE.
- Quadrant compare pairs: NE=(N,E), NW=(N,W), SE=(S,E), SW=(S,W), with first element a, second b.
- Without CONG_HYST_EN: select[q] = (a < b). Ties give 0.
- vc_mask[p][v] = !busy_next[p][v].
- LOCAL port is tracked and masked but never enters select.

## Timing
- select, vc_mask and cong are registered, with 1-cycle latency from the input event.
- Reset values:
  - all occ = 0, busy = 0, tail_sent = 0
  - select = 4'b0000
  - vc_mask = all ones
  - cong = 0
  - err = 0
- Reset mid-packet discards all state. The next cycle shows reset values regardless of inputs held during reset.
- No backpressure: every input event is consumed in the cycle it is presented.

## Configuration
- CONG_HYST_EN defined:
  - select[q] rises only when a + HYST < b.
  - select[q] falls only when b + HYST < a.
  - Otherwise select[q] holds its value.
- CONG_HYST_EN undefined: plain strict compare as above, and HYST is ignored.

## Structure
- Package nl_pkg holds:
  - port index constants NORTH..LOCAL
  - quadrant constants NE, NW, SE, SW
  - metric mode enum (CM_BUF, CM_VC, CM_HYBRID)
  - CW helper function
- Sub-module nl_vc_occ_counter: one (port, VC) occ/busy/tail_sent slice with its saturation and err output. Instantiate it NP×NV in a generate loop.
- The top level holds the metric adders, the comparators with hysteresis, and the output registers.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles with random inputs → after release, select=0, vc_mask=all ones, cong=0, err=0.
- BUF metric: MODE=0, send 3 flits on NORTH VC0 and 1 on EAST VC2 → cong[N]=3, cong[E]=1, select[NE]=0. Then return 3 NORTH credits → select[NE]=1 one cycle after the last credit.
- Ownership: head on WEST VC1 → vc_mask[W]=4'b1101 next cycle. Send tail, then return 2 credits → vc_mask[W]=4'b1111 the cycle after the final credit. With MODE=1, cong[W] goes 4→0.
- Saturation: BUF_DEPTH=4, send 5 flits on SOUTH VC3 → occ holds 4 and err=1. A credit on empty VC0 also keeps err=1 with occ=0.
- Simultaneous events: flit and credit on NORTH VC0 in the same cycle with occ=2 → occ stays 2. A flit on VC0 and a credit on VC1 in the same cycle update both.
- Hysteresis: CONG_HYST_EN, HYST=2, N=3, E=4 → select[NE] stays 0. With E=6 → rises to 1. With N=5 → holds 1. With N=9 → falls to 0.
